str_line_fifo: RTL and testbench
================================

STR_LINE_FIFO -- requirements
Module: str_line_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, character width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, buffer entries; power of two, minimum 4.
REQ-003 SHALL have parameter DELIM, default 8'h0A, line-terminator character (DATA_W bits).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  write character offered.
REQ-007 SHALL have port in_ready  output  1  write character accepted when in_valid and in_ready are both high.
REQ-008 SHALL have port in_data  input  DATA_W  write character.
REQ-009 SHALL have port out_valid  output  1  read character available.
REQ-010 SHALL have port out_ready  input  1  consumer takes the character when out_valid and out_ready are both high.
REQ-011 SHALL have port out_data  output  DATA_W  head character.
REQ-012 SHALL have port out_last  output  1  high when out_data equals DELIM.
REQ-013 SHALL have port lines_pending  output  $clog2(DEPTH)+1  count of complete lines stored.
REQ-014 SHALL have port ovf  output  1  sticky flag: a partial line was discarded.
REQ-015 SHALL have port ovf_clr  input  1  synchronous one-cycle clear of ovf.

Function
REQ-016 SHALL operate store-and-forward: out_valid high only when lines_pending>0.
REQ-017 SHALL provide zero-latency reads: out_data and out_last SHALL be valid combinationally from the head entry whenever out_valid is high.
REQ-018 SHALL run a write FSM with two states, FILL and DROP.
REQ-019 In FILL, an accepted character SHALL be stored and the write pointer advanced; an accepted DELIM SHALL increment lines_pending and record the line-start pointer as the new write pointer.
REQ-020 In FILL, in_ready SHALL be low when the buffer is full and lines_pending>0 (backpressure).
REQ-021 In FILL, when the buffer is full, lines_pending==0 and in_valid is high, the block SHALL roll the write pointer back to line start, set ovf and enter DROP. The offered character SHALL be consumed (in_ready high) and discarded.
REQ-022 In DROP, in_ready SHALL be high and all characters discarded. An accepted DELIM SHALL return the FSM to FILL without storing anything or changing lines_pending.
REQ-023 A read of an out_last character SHALL decrement lines_pending. A same-cycle DELIM write plus out_last read SHALL leave lines_pending unchanged.
REQ-024 A simultaneous read and write SHALL both complete, including when full with lines_pending>0.
REQ-025 Pointers SHALL wrap modulo DEPTH. Occupancy SHALL use an extra wrap bit, so full is DEPTH entries and empty is 0.
REQ-026 When ovf_clr and a new overflow occur in the same cycle, ovf SHALL be high (set wins).

Reset
REQ-027 On rst_n low: pointers and line-start at 0, FSM in FILL, lines_pending=0, ovf=0, out_valid=0, out_last=0, in_ready=1.
REQ-028 Reset mid-line or mid-DROP SHALL discard all buffered content; the first write after release starts a new line.

Configuration
REQ-029 Macro STR_LINE_FIFO_LINE_LEN_EN, when defined, SHALL add output last_len ($clog2(DEPTH)+1 bits).
REQ-030 last_len SHALL give the character count, including DELIM, of the most recent line completed in FILL. It SHALL update in the cycle after the DELIM is accepted and reset to 0.
REQ-031 Without the macro, the port and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Write "AB\n" (8'h41, 8'h42, 8'h0A) with out_ready=0 -> lines_pending=1. Then set out_ready=1 -> out_data reads 41, 42, 0A with out_last only on 0A, and lines_pending=0 afterward.
REQ-033 DEPTH=4: write 41,42,43,44 then 45 -> ovf=1, buffer empty, state DROP. Then write 46,0A -> lines_pending=0, state FILL, out_valid=0.
REQ-034 DEPTH=4: write "A\nB\n", then offer 43 -> in_ready=0. Read one character in the same cycle -> 43 accepted and lines_pending stays 2 until 0A is read.
REQ-035 With one line pending, write 0A while reading the last 0A in the same cycle -> lines_pending holds at 1.
REQ-036 Assert rst_n=0 after writing 41,42 -> all outputs at reset values. Then write 43,0A -> reads 43,0A only.
REQ-037 With STR_LINE_FIFO_LINE_LEN_EN defined, write "XYZ\n" -> last_len=4 the cycle after 0A. Without the macro, the bench SHALL compile with no last_len port.

Source files
------------

// File: rtl/str_line_fifo.sv
// Line-oriented store-and-forward character FIFO: a line becomes readable only once its delimiter is stored.
// Optional feature: define STR_LINE_FIFO_LINE_LEN_EN to add the last_len output.
module str_line_fifo #(
  parameter int                DATA_W = 8,
  parameter int                DEPTH  = 32,
  parameter logic [DATA_W-1:0] DELIM  = DATA_W'(8'h0A)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   lines_pending,
  output logic                     ovf,
  input  logic                     ovf_clr
`ifdef STR_LINE_FIFO_LINE_LEN_EN
  ,
  output logic [$clog2(DEPTH):0]   last_len
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {FILL, DROP} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic [AW:0]       r_line_start;
  logic [AW:0]       r_lines;
  logic              r_ovf;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [AW:0]       w_count;
  logic              w_full;
  logic [DATA_W-1:0] w_head;
  logic              w_pop;
  logic              w_in_delim;
  logic              w_in_ready;
  logic              w_push;
  logic              w_line_done;
  logic              w_overflow;

  // The extra pointer bit makes the MSB of the difference a direct full flag.
  assign w_count    = r_wptr - r_rptr;
  assign w_full     = w_count[AW];
  assign w_head     = r_mem[r_rptr[AW-1:0]];
  assign w_in_delim = (in_data == DELIM);

  assign out_valid     = (r_lines != '0);
  assign out_data      = out_valid ? w_head : '0;
  assign out_last      = out_valid && (w_head == DELIM);
  assign w_pop         = out_valid && out_ready;
  assign in_ready      = w_in_ready;
  assign lines_pending = r_lines;
  assign ovf           = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b1;
    w_push       = 1'b0;
    w_line_done  = 1'b0;
    w_overflow   = 1'b0;
    case (r_state)
      FILL: begin
        // A full buffer holding no complete line can never drain: abandon the partial line.
        if (w_full && (r_lines == '0)) begin
          if (in_valid) begin
            w_overflow   = 1'b1;
            w_state_next = DROP;
          end
        end else begin
          w_in_ready  = !w_full || out_ready;
          w_push      = in_valid && w_in_ready;
          w_line_done = w_push && w_in_delim;
        end
      end
      DROP: begin
        if (in_valid && w_in_delim) w_state_next = FILL;
      end
      default: w_state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_line_start <= '0;
      r_lines      <= '0;
      r_ovf        <= 1'b0;
    end else begin
      if (w_overflow)  r_wptr <= r_line_start;
      else if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_line_done) r_line_start <= r_wptr + 1'b1;
      if (w_pop)       r_rptr <= r_rptr + 1'b1;
      case ({w_line_done, w_pop && out_last})
        2'b10:   r_lines <= r_lines + 1'b1;
        2'b01:   r_lines <= r_lines - 1'b1;
        default: r_lines <= r_lines;
      endcase
      if (w_overflow)   r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

`ifdef STR_LINE_FIFO_LINE_LEN_EN
  logic [AW:0] r_last_len;

  // Length includes the delimiter being written this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_last_len <= '0;
    else if (w_line_done) r_last_len <= r_wptr - r_line_start + 1'b1;
  end

  assign last_len = r_last_len;
`endif

endmodule

// File: tb/tb_str_line_fifo.sv
// Directed bench for str_line_fifo (DEPTH=4); checks last_len only when STR_LINE_FIFO_LINE_LEN_EN is defined.
module tb_str_line_fifo;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic [2:0] lines_pending;
  logic       ovf;
  logic       ovf_clr;
`ifdef STR_LINE_FIFO_LINE_LEN_EN
  logic [2:0] last_len;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  str_line_fifo #(.DATA_W(8), .DEPTH(4), .DELIM(8'h0A)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .lines_pending (lines_pending),
    .ovf           (ovf),
    .ovf_clr       (ovf_clr)
`ifdef STR_LINE_FIFO_LINE_LEN_EN
    ,
    .last_len      (last_len)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
      else begin
        testsFailed++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one character for exactly one clock edge.
  task automatic applyStimulus(input logic [7:0] ch);
    in_valid = 1'b1;
    in_data  = ch;
    tick();
    in_valid = 1'b0;
    #1;
  endtask

  task automatic checkLastLen(input string tag, input logic [31:0] expected);
`ifdef STR_LINE_FIFO_LINE_LEN_EN
    checkOutput(tag, 32'(last_len), expected);
`else
    if (expected > 32'd4) $display("[TB] unexpected length argument for %s", tag);
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    #12;
    checkOutput("rst_in_ready",  32'(in_ready), 1);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_last",  32'(out_last), 0);
    checkOutput("rst_lines",     32'(lines_pending), 0);
    checkOutput("rst_ovf",       32'(ovf), 0);
    checkLastLen("rst_last_len", 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // "AB\n" held back, then streamed out
    applyStimulus(8'h41);
    checkOutput("sf_hold_valid", 32'(out_valid), 0);
    applyStimulus(8'h42);
    applyStimulus(8'h0A);
    checkOutput("ab_lines1",   32'(lines_pending), 1);
    checkOutput("ab_valid",    32'(out_valid), 1);
    checkOutput("ab_head",     32'(out_data), 32'h41);
    checkOutput("ab_head_lst", 32'(out_last), 0);
    checkLastLen("ab_last_len", 3);
    out_ready = 1'b1;
    #1;
    checkOutput("ab_rd0", 32'(out_data), 32'h41);
    tick();
    checkOutput("ab_rd1",      32'(out_data), 32'h42);
    checkOutput("ab_rd1_last", 32'(out_last), 0);
    tick();
    checkOutput("ab_rd2",       32'(out_data), 32'h0A);
    checkOutput("ab_rd2_last",  32'(out_last), 1);
    checkOutput("ab_rd2_lines", 32'(lines_pending), 1);
    tick();
    out_ready = 1'b0;
    #1;
    checkOutput("ab_end_lines", 32'(lines_pending), 0);
    checkOutput("ab_end_valid", 32'(out_valid), 0);

    // Overflow of a partial line into DROP, then recovery
    applyStimulus(8'h41);
    applyStimulus(8'h42);
    applyStimulus(8'h43);
    applyStimulus(8'h44);
    checkOutput("full_partial_ready", 32'(in_ready), 1);
    checkOutput("full_partial_valid", 32'(out_valid), 0);
    checkOutput("pre_ovf",            32'(ovf), 0);
    applyStimulus(8'h45);
    checkOutput("ovf_set",   32'(ovf), 1);
    checkOutput("ovf_valid", 32'(out_valid), 0);
    checkOutput("ovf_lines", 32'(lines_pending), 0);
    in_valid = 1'b1;
    in_data  = 8'h46;
    #1;
    checkOutput("drop_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    applyStimulus(8'h0A);
    checkOutput("drop_exit_lines", 32'(lines_pending), 0);
    checkOutput("drop_exit_valid", 32'(out_valid), 0);
    checkOutput("ovf_sticky",      32'(ovf), 1);
    checkLastLen("drop_last_len", 3);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    #1;
    checkOutput("ovf_cleared", 32'(ovf), 0);
    applyStimulus(8'h41);
    applyStimulus(8'h0A);
    checkOutput("fill_again_lines", 32'(lines_pending), 1);
    checkOutput("fill_again_head",  32'(out_data), 32'h41);
    checkLastLen("fill_again_len", 2);
    out_ready = 1'b1;
    tick();
    checkOutput("fill_again_rd", 32'(out_data), 32'h0A);
    tick();
    out_ready = 1'b0;
    #1;
    checkOutput("fill_again_empty", 32'(lines_pending), 0);

    // Backpressure when full with complete lines, released by a same-cycle read
    applyStimulus(8'h41);
    applyStimulus(8'h0A);
    applyStimulus(8'h42);
    applyStimulus(8'h0A);
    checkOutput("bp_lines2", 32'(lines_pending), 2);
    in_valid = 1'b1;
    in_data  = 8'h43;
    #1;
    checkOutput("bp_ready_low", 32'(in_ready), 0);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_ready_rd", 32'(in_ready), 1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    checkOutput("bp_lines_hold", 32'(lines_pending), 2);
    checkOutput("bp_head",       32'(out_data), 32'h0A);
    checkOutput("bp_head_last",  32'(out_last), 1);
    out_ready = 1'b1;
    tick();
    checkOutput("bp_lines1", 32'(lines_pending), 1);
    checkOutput("bp_rd42",   32'(out_data), 32'h42);
    tick();
    checkOutput("bp_rd0a", 32'(out_data), 32'h0A);
    tick();
    out_ready = 1'b0;
    #1;
    checkOutput("bp_lines0", 32'(lines_pending), 0);
    checkOutput("bp_valid0", 32'(out_valid), 0);
    applyStimulus(8'h0A);
    checkOutput("bp_tail_lines", 32'(lines_pending), 1);
    checkOutput("bp_tail_head",  32'(out_data), 32'h43);
    checkLastLen("bp_tail_len", 2);

    // Same-cycle delimiter write and last-character read
    out_ready = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data  = 8'h0A;
    #1;
    checkOutput("same_pre_last", 32'(out_last), 1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    checkOutput("same_lines",    32'(lines_pending), 1);
    checkOutput("same_head",     32'(out_data), 32'h0A);
    checkOutput("same_head_lst", 32'(out_last), 1);
    checkLastLen("same_len", 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    checkOutput("same_drained", 32'(lines_pending), 0);

    // Overflow and clear in the same cycle: set wins
    applyStimulus(8'h41);
    applyStimulus(8'h42);
    applyStimulus(8'h43);
    applyStimulus(8'h44);
    in_valid = 1'b1;
    in_data  = 8'h45;
    ovf_clr  = 1'b1;
    tick();
    in_valid = 1'b0;
    ovf_clr  = 1'b0;
    #1;
    checkOutput("ovf_set_wins", 32'(ovf), 1);
    applyStimulus(8'h0A);
    checkOutput("sw_exit_lines", 32'(lines_pending), 0);

    // Asynchronous reset mid-line discards content
    applyStimulus(8'h41);
    applyStimulus(8'h42);
    checkOutput("pre_rst_valid", 32'(out_valid), 0);
    checkOutput("pre_rst_ovf",   32'(ovf), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_in_ready",  32'(in_ready), 1);
    checkOutput("arst_out_valid", 32'(out_valid), 0);
    checkOutput("arst_out_last",  32'(out_last), 0);
    checkOutput("arst_lines",     32'(lines_pending), 0);
    checkOutput("arst_ovf",       32'(ovf), 0);
    checkLastLen("arst_last_len", 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    applyStimulus(8'h43);
    applyStimulus(8'h0A);
    checkOutput("post_rst_lines", 32'(lines_pending), 1);
    checkOutput("post_rst_head",  32'(out_data), 32'h43);
    checkLastLen("post_rst_len", 2);
    out_ready = 1'b1;
    tick();
    checkOutput("post_rst_rd",   32'(out_data), 32'h0A);
    checkOutput("post_rst_last", 32'(out_last), 1);
    tick();
    out_ready = 1'b0;
    #1;
    checkOutput("post_rst_empty", 32'(lines_pending), 0);
    checkOutput("post_rst_valid", 32'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
